// File: rtl/dmux_rr_if.sv
// Requester/lane bundle for the round-robin demux scheduler.
//   master : producer side, drives req/last/din, observes grant and lanes
//   slave  : scheduler side, drives gnt/sel/dout/dvld/busy
// Ports carried:
//   req  [NREQ]    per-requester request (beat valid while granted)
//   last [NREQ]    per-requester end-of-burst marker
//   din  [NREQ*DW] packed requester data, slice i = din[i*DW +: DW]
//   gnt  [NREQ]    one-hot registered grant
//   sel  [3]       binary demux select of current/last grant
//   dout [NREQ*DW] packed lane outputs, only the selected lane non-zero
//   dvld [NREQ]    one-hot registered beat-valid per lane
//   busy           high while in GRANT or GAP
interface dmux_rr_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         sel;
  logic [NREQ*DW-1:0] dout;
  logic [NREQ-1:0]    dvld;
  logic               busy;

  modport master (output req, last, din, input gnt, sel, dout, dvld, busy);
  modport slave  (input req, last, din, output gnt, sel, dout, dvld, busy);
endinterface

// File: rtl/dmux_rr_scheduler.sv
// Round-robin scheduler sharing one registered 1:NREQ demux among NREQ
// requesters. Requester i owns lane i; one grant at a time, bursts end on
// last, on MAX_BURST beats, or when the granted requester drops req. Every
// grant is followed by a one-cycle GAP (select turnaround) before the next
// arbitration in IDLE.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dmux_rr_if.slave (req/last/din in, gnt/sel/dout/dvld/busy out)
// Optional build macro DMUX_SCHED_PRIO_EN: requester 0 wins every IDLE
// arbitration it takes part in; others stay round-robin. No preemption.
module dmux_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic     clk,
  input  logic     rst,
  dmux_rr_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e                      state_q, state_d;
  logic   [NREQ-1:0]           gnt_q, gnt_d;
  logic   [SW-1:0]             w_q, w_d;      // current/last winner
  logic   [SW-1:0]             ptr_q, ptr_d;  // last released requester
  logic   [7:0]                cnt_q, cnt_d;
  logic   [NREQ-1:0]           dvld_q, dvld_d;
  logic   [NREQ-1:0][DW-1:0]   dout_q, dout_d;

  logic          beat;
  logic          found;
  logic [SW-1:0] win;
  int            idx;

  // Arbitration: first requester after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
`ifdef DMUX_SCHED_PRIO_EN
    if (bus.req[0]) win = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    w_d     = w_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << win;
          w_d     = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        beat = bus.req[w_q];
        if (beat) cnt_d = cnt_q + 8'd1;
        // Releasing beat is still forwarded; a dropped req is not a beat.
        if (!bus.req[w_q] || bus.last[w_q] || (cnt_q + 8'd1 == 8'(MAX_BURST))) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = w_q;
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Lane steering: only the granted lane carries data, others forced to 0.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign dvld_d[i] = beat && (w_q == SW'(i));
    assign dout_d[i] = dvld_d[i] ? bus.din[i*DW +: DW] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      w_q     <= '0;
      ptr_q   <= SW'(NREQ-1);
      cnt_q   <= '0;
      dvld_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dvld_q  <= dvld_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = 3'(w_q);
  assign bus.dvld = dvld_q;
  assign bus.dout = dout_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_dmux_rr_scheduler.sv
module tb_dmux_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 8;
  localparam logic [31:0] DIN = 32'h4433_22A5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmux_rr_if #(.NREQ(NREQ), .DW(DW)) bus ();

  dmux_rr_scheduler #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [2:0]  sel;
    logic [3:0]  dvld;
    logic [31:0] dout;
    logic        busy;
  } vec_t;

  vec_t tv [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input logic [3:0] g, input logic [2:0] s,
                           input logic [3:0] v, input logic [31:0] d, input logic b);
    check({nm, "_gnt"},  32'(bus.gnt),  32'(g));
    check({nm, "_sel"},  32'(bus.sel),  32'(s));
    check({nm, "_dvld"}, 32'(bus.dvld), 32'(v));
    check({nm, "_dout"}, bus.dout,      d);
    check({nm, "_busy"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] lane_of(input int w);
    logic [31:0] m;
    m = 32'hFF << (8 * w);
    return DIN & m;
  endfunction

  initial begin
    logic [3:0] oh;
    int         w;
    int         pw;
    checks  = 0;
    errors  = 0;
    bus.din = DIN;

    // {req, last, gnt, sel, dvld, dout, busy}: inputs for a cycle, outputs after its edge
    tv[0]  = '{4'b0001, 4'b0000, 4'b0001, 3'd0, 4'b0000, 32'h0,         1'b1};
    tv[1]  = '{4'b0001, 4'b0000, 4'b0001, 3'd0, 4'b0001, 32'h0000_00A5, 1'b1};
    tv[2]  = '{4'b0001, 4'b0000, 4'b0001, 3'd0, 4'b0001, 32'h0000_00A5, 1'b1};
    tv[3]  = '{4'b0001, 4'b0001, 4'b0000, 3'd0, 4'b0001, 32'h0000_00A5, 1'b1};
    tv[4]  = '{4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, 32'h0,         1'b0};
    tv[5]  = '{4'b0000, 4'b0000, 4'b0000, 3'd0, 4'b0000, 32'h0,         1'b0};
    tv[6]  = '{4'b0100, 4'b0000, 4'b0100, 3'd2, 4'b0000, 32'h0,         1'b1};
    tv[7]  = '{4'b0100, 4'b0100, 4'b0000, 3'd2, 4'b0100, 32'h0033_0000, 1'b1};
    tv[8]  = '{4'b0101, 4'b0000, 4'b0000, 3'd2, 4'b0000, 32'h0,         1'b0};
    tv[9]  = '{4'b0101, 4'b0000, 4'b0001, 3'd0, 4'b0000, 32'h0,         1'b1};
    tv[10] = '{4'b0101, 4'b0000, 4'b0001, 3'd0, 4'b0001, 32'h0000_00A5, 1'b1};
    tv[11] = '{4'b0101, 4'b0000, 4'b0001, 3'd0, 4'b0001, 32'h0000_00A5, 1'b1};
    tv[12] = '{4'b0100, 4'b0000, 4'b0000, 3'd0, 4'b0000, 32'h0,         1'b1};
    tv[13] = '{4'b0100, 4'b0000, 4'b0000, 3'd0, 4'b0000, 32'h0,         1'b0};
    tv[14] = '{4'b0100, 4'b0000, 4'b0100, 3'd2, 4'b0000, 32'h0,         1'b1};
    tv[15] = '{4'b0100, 4'b0100, 4'b0000, 3'd2, 4'b0100, 32'h0033_0000, 1'b1};
    tv[16] = '{4'b0000, 4'b0000, 4'b0000, 3'd2, 4'b0000, 32'h0,         1'b0};

    // Reset state
    rst      = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    step();
    check_all("reset", 4'b0000, 3'd0, 4'b0000, 32'h0, 1'b0);
    step();
    rst = 1'b0;

    // Table: 3-beat burst with last, wrap-around from ptr=2, mid-burst drop
    for (int i = 0; i < 17; i++) begin
      bus.req  = tv[i].req;
      bus.last = tv[i].last;
      step();
      check_all($sformatf("tv%0d", i), tv[i].gnt, tv[i].sel, tv[i].dvld, tv[i].dout, tv[i].busy);
    end

    // Fairness: all requesting, no last -> MAX_BURST beats per grant
    do_reset();
    bus.req  = 4'b1111;
    bus.last = 4'b0000;
    for (int g = 0; g < 5; g++) begin
`ifdef DMUX_SCHED_PRIO_EN
      w = 0;
`else
      w = g % NREQ;
`endif
      oh = 4'b0001 << w;
      step();
      check_all($sformatf("rr%0d_arb", g), oh, 3'(w), 4'b0000, 32'h0, 1'b1);
      for (int b = 1; b <= MB; b++) begin
        step();
        check_all($sformatf("rr%0d_b%0d", g, b), (b < MB) ? oh : 4'b0000, 3'(w), oh, lane_of(w), 1'b1);
      end
      step();
      check_all($sformatf("rr%0d_gap", g), 4'b0000, 3'(w), 4'b0000, 32'h0, 1'b0);
    end

    // req=0011 with single-beat bursts: alternates, or always 0 with priority
    do_reset();
    bus.req  = 4'b0011;
    bus.last = 4'b0011;
    pw = -1;
    for (int g = 0; g < 4; g++) begin
`ifdef DMUX_SCHED_PRIO_EN
      w = 0;
`else
      w = g % 2;
`endif
      oh = 4'b0001 << w;
      step();
      check($sformatf("pr%0d_gnt", g), 32'(bus.gnt), 32'(oh));
      step();
      check($sformatf("pr%0d_dvld", g), 32'(bus.dvld), 32'(oh));
      check($sformatf("pr%0d_dout", g), bus.dout, lane_of(w));
      step();
      check($sformatf("pr%0d_gap", g), 32'(bus.dvld | bus.gnt), 32'h0);
      pw = w;
    end

    // Reset during beat 4 of a lane-3 burst
    do_reset();
    bus.req  = 4'b1000;
    bus.last = 4'b0000;
    step();
    check_all("mr_arb", 4'b1000, 3'd3, 4'b0000, 32'h0, 1'b1);
    for (int b = 1; b <= 3; b++) begin
      step();
      check_all($sformatf("mr_b%0d", b), 4'b1000, 3'd3, 4'b1000, lane_of(3), 1'b1);
    end
    rst = 1'b1;
    step();
    check_all("mr_rst", 4'b0000, 3'd0, 4'b0000, 32'h0, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    step();
    check_all("mr_rearb", 4'b0001, 3'd0, 4'b0000, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
